// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and defaults for the memory port arbiter:
//   - arb_state_e : arbiter FSM states (IDLE / BUSY / RESP)
//   - grant_e     : which requester owns the current access
//   - DEF_LATENCY, DEF_MAX_IF_WAIT : default parameter values
//   - lat_cnt_width() : width of the latency down-counter for a given LATENCY
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    localparam int DEF_LATENCY     = 2;
    localparam int DEF_MAX_IF_WAIT = 4;

    // The counter holds LATENCY-1 down to 0. Sizing on LATENCY+1 keeps
    // the width at least 1 bit when LATENCY is 1.
    function automatic int lat_cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_counter.sv
// mem_arb_starve_counter
//   Counts consecutive arbitrations the fetch port has lost, saturating at
//   MAX_IF_WAIT. Clear has priority over increment.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     inc_i       : fetch requested but memory stage won this arbitration
//     clr_i       : fetch granted, or fetch not requesting in IDLE
//     reached_o   : count equals MAX_IF_WAIT (fetch must win next)
module mem_arb_starve_counter #(
    parameter int MAX_IF_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic reached_o
);

    localparam int CW = $clog2(MAX_IF_WAIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != CW'(MAX_IF_WAIT)))
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign reached_o = (cnt_q == CW'(MAX_IF_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported RAM between the fetch stage (read only) and the
//   memory stage (load/store). One access at a time: IDLE arbitrates, BUSY
//   drives the RAM for LATENCY cycles, RESP pulses the winner's ack.
//   Memory stage has priority unless fetch has lost MAX_IF_WAIT times in a row.
//   Ports:
//     clk, reset                    : clock, asynchronous active-low reset
//     if_req/if_addr                : fetch request
//     if_ack/if_rdata               : fetch completion pulse and data
//     mem_req/mem_we/mem_addr/mem_wdata : memory-stage request
//     mem_ack/mem_rdata             : memory-stage completion pulse and data
//     ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : shared RAM port
//     if_stall/mem_stall            : request pending and not yet acked
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NBits       = 32,
    parameter int LATENCY     = DEF_LATENCY,
    parameter int MAX_IF_WAIT = DEF_MAX_IF_WAIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [NBits-1:0] if_addr,
    output logic             if_ack,
    output logic [NBits-1:0] if_rdata,
    input  logic             mem_req,
    input  logic             mem_we,
    input  logic [NBits-1:0] mem_addr,
    input  logic [NBits-1:0] mem_wdata,
    output logic             mem_ack,
    output logic [NBits-1:0] mem_rdata,
    output logic             ram_en,
    output logic             ram_we,
    output logic [NBits-1:0] ram_addr,
    output logic [NBits-1:0] ram_wdata,
    input  logic [NBits-1:0] ram_rdata,
    output logic             if_stall,
    output logic             mem_stall
);

    localparam int CNT_W = lat_cnt_width(LATENCY);

    arb_state_e       state_q, state_d;
    grant_e           grant_q, grant_d;
    logic [NBits-1:0] addr_q, addr_d;
    logic [NBits-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBits-1:0] if_rdata_q, if_rdata_d;
    logic [NBits-1:0] mem_rdata_q, mem_rdata_d;

    logic starve_inc, starve_clr, starve_reached;

    mem_arb_starve_counter #(
        .MAX_IF_WAIT (MAX_IF_WAIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (reset),
        .inc_i     (starve_inc),
        .clr_i     (starve_clr),
        .reached_o (starve_reached)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        starve_inc  = 1'b0;
        starve_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    // Memory stage wins unless fetch is also waiting and
                    // has already been passed over MAX_IF_WAIT times.
                    if (mem_req && !(if_req && starve_reached)) begin
                        grant_d    = GRANT_MEM;
                        addr_d     = mem_addr;
                        starve_inc = if_req;
                        starve_clr = !if_req;
                    end else begin
                        grant_d    = GRANT_IF;
                        addr_d     = if_addr;
                        starve_clr = 1'b1;
                    end
                    we_d    = mem_we;
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end else begin
                    starve_clr = 1'b1;
                end
            end

            BUSY: begin
                if (cnt_q == '0) begin
                    // Last RAM cycle: capture read data for the winner.
                    if (grant_q == GRANT_IF)
                        if_rdata_d = ram_rdata;
                    else
                        mem_rdata_d = we_q ? '0 : ram_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= GRANT_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Address/data registers only change on arbitration, so they already
    // hold their last value outside BUSY.
    assign ram_en    = (state_q == BUSY);
    assign ram_we    = (state_q == BUSY) && (grant_q == GRANT_MEM) && we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign if_ack    = (state_q == RESP) && (grant_q == GRANT_IF);
    assign mem_ack   = (state_q == RESP) && (grant_q == GRANT_MEM);
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    assign if_stall  = if_req  && !if_ack;
    assign mem_stall = mem_req && !mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed vectors with hand-computed expectations for mem_port_arbiter
//   at default parameters (NBits=32, LATENCY=2, MAX_IF_WAIT=4).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
    logic        if_ack, mem_ack, ram_en, ram_we, if_stall, mem_stall;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .if_stall  (if_stall),
        .mem_stall (mem_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        if_addr   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        ram_rdata = '0;

        // ---- reset state
        tick(); tick();
        chk("rst_ram_en",    ram_en,    0);
        chk("rst_ram_we",    ram_we,    0);
        chk("rst_if_ack",    if_ack,    0);
        chk("rst_mem_ack",   mem_ack,   0);
        chk("rst_ram_addr",  ram_addr,  0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_if_rdata",  if_rdata,  0);
        chk("rst_mem_rdata", mem_rdata, 0);
        reset = 1'b1;

        // ---- fetch read
        if_req = 1'b1; if_addr = 32'h0040_0000; ram_rdata = 32'h2008_0005;
        #1;
        chk("f_stall0", if_stall, 1);
        tick();
        chk("f_en1",   ram_en,   1);
        chk("f_we1",   ram_we,   0);
        chk("f_addr1", ram_addr, 32'h0040_0000);
        chk("f_ack1",  if_ack,   0);
        tick();
        chk("f_en2",   ram_en,   1);
        chk("f_ack2",  if_ack,   0);
        tick();
        chk("f_en3",    ram_en,   0);
        chk("f_ack3",   if_ack,   1);
        chk("f_mack3",  mem_ack,  0);
        chk("f_rdata",  if_rdata, 32'h2008_0005);
        chk("f_stall3", if_stall, 0);
        if_req = 1'b0;
        tick();
        chk("f_ack4",   if_ack,   0);
        chk("f_hold",   if_rdata, 32'h2008_0005);
        chk("f_ahold",  ram_addr, 32'h0040_0000);

        // ---- store
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1001_0004;
        mem_wdata = 32'hDEAD_BEEF; ram_rdata = 32'h1234_5678;
        tick();
        chk("s_en1",   ram_en,    1);
        chk("s_we1",   ram_we,    1);
        chk("s_addr1", ram_addr,  32'h1001_0004);
        chk("s_wd1",   ram_wdata, 32'hDEAD_BEEF);
        mem_wdata = 32'h0BAD_0BAD;   // must be ignored while BUSY
        tick();
        chk("s_we2",   ram_we,    1);
        chk("s_wd2",   ram_wdata, 32'hDEAD_BEEF);
        tick();
        chk("s_ack",   mem_ack,   1);
        chk("s_we3",   ram_we,    0);
        chk("s_rdata", mem_rdata, 0);
        chk("s_whold", ram_wdata, 32'hDEAD_BEEF);
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        chk("s_ack4",  mem_ack,   0);

        // ---- simultaneous requests: mem first, then fetch
        if_req = 1'b1; if_addr = 32'h0040_0004;
        mem_req = 1'b1; mem_addr = 32'h1001_0000; ram_rdata = 32'hCAFE_F00D;
        tick();
        chk("b_addr1",  ram_addr, 32'h1001_0000);
        chk("b_we1",    ram_we,   0);
        tick();
        tick();
        chk("b_mack3",  mem_ack,   1);
        chk("b_iack3",  if_ack,    0);
        chk("b_mrd",    mem_rdata, 32'hCAFE_F00D);
        chk("b_istl3",  if_stall,  1);
        mem_req = 1'b0;
        tick();
        chk("b_idle4",  ram_en,   0);
        chk("b_istl4",  if_stall, 1);
        tick();
        chk("b_addr5",  ram_addr, 32'h0040_0004);
        ram_rdata = 32'h0BAD_F00D;
        tick();
        chk("b_iack6",  if_ack,   0);
        tick();
        chk("b_iack7",  if_ack,    1);
        chk("b_ird",    if_rdata,  32'h0BAD_F00D);
        chk("b_mhold",  mem_rdata, 32'hCAFE_F00D);
        chk("b_istl7",  if_stall,  0);
        if_req = 1'b0;
        tick();

        // ---- starvation: both held, expect M M M M I M M M M I
        if_req = 1'b1; if_addr = 32'h0040_0100;
        mem_req = 1'b1; mem_addr = 32'h1001_0100;
        for (int k = 0; k < 10; k++) begin
            automatic bit exp_if = (k == 4) || (k == 9);
            tick();
            chk($sformatf("st_addr%0d", k), ram_addr,
                exp_if ? 32'h0040_0100 : 32'h1001_0100);
            tick();
            tick();
            chk($sformatf("st_iack%0d", k), if_ack,  exp_if);
            chk($sformatf("st_mack%0d", k), mem_ack, !exp_if);
            tick();
        end
        if_req = 1'b0; mem_req = 1'b0;
        tick();

        // ---- reset in the middle of an access
        if_req = 1'b1; if_addr = 32'h0040_0008; ram_rdata = 32'h55AA_55AA;
        tick();
        tick();
        chk("r_busy2", ram_en, 1);
        reset = 1'b0;
        #1;
        chk("r_en",    ram_en,   0);
        chk("r_addr",  ram_addr, 0);
        chk("r_ird",   if_rdata, 0);
        tick();
        chk("r_ack",   if_ack,   0);
        reset = 1'b1;
        tick();
        chk("r_en1",   ram_en,   1);
        chk("r_addr1", ram_addr, 32'h0040_0008);
        tick();
        tick();
        chk("r_ack3",  if_ack,   1);
        chk("r_ird3",  if_rdata, 32'h55AA_55AA);
        if_req = 1'b0;
        tick();

        // ---- memory request dropped during BUSY
        mem_req = 1'b1; mem_addr = 32'h1001_0008; ram_rdata = 32'h0000_0077;
        tick();
        chk("d_en1",  ram_en, 1);
        mem_req = 1'b0;
        tick();
        tick();
        chk("d_ack",  mem_ack,   1);
        chk("d_mrd",  mem_rdata, 32'h0000_0077);
        tick();
        chk("d_ack4", mem_ack, 0);
        chk("d_en4",  ram_en,  0);
        tick();
        chk("d_en5",  ram_en,  0);
        chk("d_ack5", mem_ack, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
